led_seq_ctrl: RTL and testbench

Sequencing controller for the 4-LED pattern engine (bounce / shift-left / shift-right).
- Takes single-cycle button pulses from the existing debouncers.
- Owns pattern selection, step timing, speed, and an auto-cycle/pause mode FSM.
- Drives the pattern engine with PATTERN, STEP and STEP_EN. The engine stays a pure lookup (pattern, step) -> LED.

---
 rtl/led_pkg.sv | 39 +++
 rtl/led_step_prescaler.sv | 54 +++++
 rtl/led_seq_ctrl.sv | 121 ++++++++++++
 tb/tb_led_seq_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared codes, step lengths and helpers for the LED sequencer
package led_pkg;

  typedef enum logic [1:0] {
    PAT_BOUNCE = 2'd0,
    PAT_LEFT   = 2'd1,
    PAT_RIGHT  = 2'd2
  } pattern_e;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'd0,
    MODE_AUTO   = 2'd1,
    MODE_PAUSE  = 2'd2
  } mode_e;

  localparam logic [2:0] LEN_BOUNCE = 3'd6;
  localparam logic [2:0] LEN_SHIFT  = 3'd4;

  function automatic pattern_e pat_next(input pattern_e p);
    case (p)
      PAT_BOUNCE: return PAT_LEFT;
      PAT_LEFT:   return PAT_RIGHT;
      default:    return PAT_BOUNCE;
    endcase
  endfunction

  function automatic pattern_e pat_prev(input pattern_e p);
    case (p)
      PAT_BOUNCE: return PAT_RIGHT;
      PAT_RIGHT:  return PAT_LEFT;
      default:    return PAT_BOUNCE;
    endcase
  endfunction

  function automatic logic [2:0] last_step(input pattern_e p);
    return (p == PAT_BOUNCE) ? (LEN_BOUNCE - 3'd1) : (LEN_SHIFT - 3'd1);
  endfunction

endpackage

// File: rtl/led_step_prescaler.sv
// rtl/led_step_prescaler.sv - free-running prescaler and speed divider producing step ticks
module led_step_prescaler #(
  parameter int TICK_W = 23
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       clear_i,
  input  logic       div_clear_i,
  input  logic       hold_i,
  input  logic [1:0] speed_i,
  output logic       tick_o
);

  logic [TICK_W-1:0] pre_q, pre_d;
  logic [2:0]        div_q, div_d;
  logic [2:0]        mask;
  logic              base_tick;

  always_comb begin
    case (speed_i)
      2'd0:    mask = 3'b000;
      2'd1:    mask = 3'b001;
      2'd2:    mask = 3'b011;
      default: mask = 3'b111;
    endcase
  end

  assign base_tick = !hold_i && (&pre_q);
  assign tick_o    = base_tick && ((div_q & mask) == mask);

  // A full clear beats hold so a pattern change while paused restarts timing
  always_comb begin
    pre_d = pre_q;
    if (clear_i)     pre_d = '0;
    else if (!hold_i) pre_d = pre_q + TICK_W'(1);
  end

  always_comb begin
    div_d = div_q;
    if (clear_i || div_clear_i) div_d = '0;
    else if (base_tick)         div_d = div_q + 3'd1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pre_q <= '0;
      div_q <= '0;
    end else begin
      pre_q <= pre_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// rtl/led_seq_ctrl.sv - pattern, step and mode sequencing for the 4-LED pattern engine
module led_seq_ctrl
  import led_pkg::*;
#(
  parameter int TICK_W      = 23,
  parameter int AUTO_SWEEPS = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       UP_P,
  input  logic       DOWN_P,
  input  logic       MODE_P,
  input  logic       SPEED_P,
  output logic [1:0] PATTERN,
  output logic [2:0] STEP,
  output logic       STEP_EN,
  output logic [1:0] MODE,
  output logic [1:0] SPEED
);

  localparam logic [3:0] SWEEP_LAST = 4'(AUTO_SWEEPS - 1);

  pattern_e   pattern_q, pattern_d;
  mode_e      mode_q, mode_d;
  logic [2:0] step_q, step_d;
  logic       step_en_q, step_en_d;
  logic [1:0] speed_q, speed_d;
  logic [3:0] sweep_q, sweep_d;
  logic       up_q, down_q;

  logic pat_chg, step_tick, hold, auto_en, auto_entry, wrap;

  led_step_prescaler #(.TICK_W(TICK_W)) u_presc (
    .clk_i       (CLK),
    .rst_n_i     (RST),
    .clear_i     (pat_chg),
    .div_clear_i (SPEED_P),
    .hold_i      (hold),
    .speed_i     (speed_q),
    .tick_o      (step_tick)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) mode_q <= MODE_MANUAL;
    else      mode_q <= mode_d;
  end

  always_comb begin
    mode_d = mode_q;
    if (MODE_P) begin
      case (mode_q)
        MODE_MANUAL: mode_d = MODE_AUTO;
        MODE_AUTO:   mode_d = MODE_PAUSE;
        default:     mode_d = MODE_MANUAL;
      endcase
    end
  end

  always_comb begin
    hold       = (mode_q == MODE_PAUSE);
    auto_en    = (mode_q == MODE_AUTO);
    auto_entry = MODE_P && (mode_q == MODE_MANUAL);
  end

  // Button pulses are staged one cycle; opposing presses cancel out
  assign pat_chg = up_q ^ down_q;
  assign wrap    = (step_q == last_step(pattern_q));

  always_comb begin
    pattern_d = pattern_q;
    step_d    = step_q;
    step_en_d = 1'b0;
    sweep_d   = sweep_q;
    if (pat_chg) begin
      pattern_d = up_q ? pat_next(pattern_q) : pat_prev(pattern_q);
      step_d    = 3'd0;
      sweep_d   = 4'd0;
    end else if (step_tick) begin
      step_en_d = 1'b1;
      step_d    = wrap ? 3'd0 : step_q + 3'd1;
      if (wrap && auto_en) begin
        if (sweep_q == SWEEP_LAST) begin
          pattern_d = pat_next(pattern_q);
          sweep_d   = 4'd0;
        end else begin
          sweep_d   = sweep_q + 4'd1;
        end
      end
    end
    if (auto_entry) sweep_d = 4'd0;
  end

  assign speed_d = SPEED_P ? speed_q + 2'd1 : speed_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pattern_q <= PAT_BOUNCE;
      step_q    <= 3'd0;
      step_en_q <= 1'b0;
      speed_q   <= 2'd0;
      sweep_q   <= 4'd0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      step_q    <= step_d;
      step_en_q <= step_en_d;
      speed_q   <= speed_d;
      sweep_q   <= sweep_d;
      up_q      <= UP_P;
      down_q    <= DOWN_P;
    end
  end

  assign PATTERN = pattern_q;
  assign STEP    = step_q;
  assign STEP_EN = step_en_q;
  assign MODE    = mode_q;
  assign SPEED   = speed_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb/tb_led_seq_ctrl.sv - vector table, corner sequences and randomized model check for led_seq_ctrl
module tb_led_seq_ctrl;

  localparam int TICK_W      = 4;
  localparam int AUTO_SWEEPS = 4;
  localparam int PRE_N       = 1 << TICK_W;

  logic       CLK = 1'b0;
  logic       RST;
  logic       UP_P, DOWN_P, MODE_P, SPEED_P;
  logic [1:0] PATTERN;
  logic [2:0] STEP;
  logic       STEP_EN;
  logic [1:0] MODE;
  logic [1:0] SPEED;

  int vectors     = 0;
  int miscompares = 0;

  led_seq_ctrl #(.TICK_W(TICK_W), .AUTO_SWEEPS(AUTO_SWEEPS)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .UP_P    (UP_P),
    .DOWN_P  (DOWN_P),
    .MODE_P  (MODE_P),
    .SPEED_P (SPEED_P),
    .PATTERN (PATTERN),
    .STEP    (STEP),
    .STEP_EN (STEP_EN),
    .MODE    (MODE),
    .SPEED   (SPEED)
  );

  always #5 CLK = ~CLK;

  // Reference model: pattern/step/timing rules expressed as integer arithmetic
  int m_pat = 0, m_step = 0, m_mode = 0, m_speed = 0;
  int m_phase = 0, m_ticks = 0, m_sweeps = 0;
  bit m_en = 1'b0, m_upd = 1'b0, m_dnd = 1'b0;

  initial begin
    forever begin
      @(posedge CLK or negedge RST);
      if (!RST) begin
        m_pat = 0; m_step = 0; m_en = 1'b0; m_mode = 0; m_speed = 0;
        m_phase = 0; m_ticks = 0; m_sweeps = 0; m_upd = 1'b0; m_dnd = 1'b0;
      end else begin
        bit paused, base, stp, chg, u, d, mo, sp;
        int per, len;
        u = UP_P; d = DOWN_P; mo = MODE_P; sp = SPEED_P;
        paused = (m_mode == 2);
        base   = !paused && (m_phase == PRE_N - 1);
        per    = 1 << m_speed;
        stp    = base && ((m_ticks % per) == per - 1);
        chg    = (m_upd != m_dnd);
        len    = (m_pat == 0) ? 6 : 4;
        if (chg) begin
          m_pat = m_upd ? (m_pat + 1) % 3 : (m_pat + 2) % 3;
          m_step = 0; m_en = 1'b0; m_phase = 0; m_ticks = 0; m_sweeps = 0;
        end else begin
          if (!paused) m_phase = (m_phase + 1) % PRE_N;
          if (base) m_ticks = m_ticks + 1;
          m_en = stp;
          if (stp) begin
            m_step = (m_step + 1) % len;
            if (m_step == 0 && m_mode == 1) begin
              m_sweeps = m_sweeps + 1;
              if (m_sweeps == AUTO_SWEEPS) begin
                m_pat = (m_pat + 1) % 3;
                m_sweeps = 0;
              end
            end
          end
        end
        if (sp) begin m_speed = (m_speed + 1) % 4; m_ticks = 0; end
        if (mo) begin
          if (m_mode == 0) m_sweeps = 0;
          m_mode = (m_mode + 1) % 3;
        end
        m_upd = u; m_dnd = d;
      end
    end
  end

  typedef struct {
    logic [3:0] p;
    int         w;
    logic [1:0] pat;
    logic [2:0] step;
    logic       en;
    logic [1:0] mode;
    logic [1:0] speed;
  } vec_t;

  vec_t tbl[25];

  function automatic vec_t mk(input logic [3:0] p, input int w, input logic [1:0] pat,
                              input logic [2:0] step, input logic en, input logic [1:0] mode,
                              input logic [1:0] speed);
    vec_t v;
    v.p = p; v.w = w; v.pat = pat; v.step = step; v.en = en; v.mode = mode; v.speed = speed;
    return v;
  endfunction

  task automatic check(input string nm, input logic [1:0] ep, input logic [2:0] es,
                       input logic ee, input logic [1:0] em, input logic [1:0] esp);
    vectors++;
    if (PATTERN !== ep || STEP !== es || STEP_EN !== ee || MODE !== em || SPEED !== esp) begin
      miscompares++;
      $display("FAIL %s t=%0t: got pat=%0d step=%0d en=%0d mode=%0d speed=%0d, want pat=%0d step=%0d en=%0d mode=%0d speed=%0d",
               nm, $time, PATTERN, STEP, STEP_EN, MODE, SPEED, ep, es, ee, em, esp);
    end
  endtask

  task automatic check_model(input string nm);
    check(nm, 2'(m_pat), 3'(m_step), m_en, 2'(m_mode), 2'(m_speed));
  endtask

  // p = {up, down, mode, speed}; w = rising edges from the pulse edge to the check
  task automatic pulse(input logic [3:0] p, input int w);
    {UP_P, DOWN_P, MODE_P, SPEED_P} = p;
    @(negedge CLK);
    {UP_P, DOWN_P, MODE_P, SPEED_P} = 4'b0000;
    repeat (w - 1) @(negedge CLK);
  endtask

  initial begin
    tbl[0]  = mk(4'b0000, 15, 2'd0, 3'd0, 1'b0, 2'd0, 2'd0);
    tbl[1]  = mk(4'b0000,  1, 2'd0, 3'd1, 1'b1, 2'd0, 2'd0);
    tbl[2]  = mk(4'b0000,  1, 2'd0, 3'd1, 1'b0, 2'd0, 2'd0);
    tbl[3]  = mk(4'b0000, 64, 2'd0, 3'd5, 1'b0, 2'd0, 2'd0);
    tbl[4]  = mk(4'b0000, 15, 2'd0, 3'd0, 1'b1, 2'd0, 2'd0);
    tbl[5]  = mk(4'b1000,  2, 2'd1, 3'd0, 1'b0, 2'd0, 2'd0);
    tbl[6]  = mk(4'b0000, 15, 2'd1, 3'd0, 1'b0, 2'd0, 2'd0);
    tbl[7]  = mk(4'b0000,  1, 2'd1, 3'd1, 1'b1, 2'd0, 2'd0);
    tbl[8]  = mk(4'b1000,  2, 2'd2, 3'd0, 1'b0, 2'd0, 2'd0);
    tbl[9]  = mk(4'b1000,  2, 2'd0, 3'd0, 1'b0, 2'd0, 2'd0);
    tbl[10] = mk(4'b0100,  2, 2'd2, 3'd0, 1'b0, 2'd0, 2'd0);
    tbl[11] = mk(4'b0100,  2, 2'd1, 3'd0, 1'b0, 2'd0, 2'd0);
    tbl[12] = mk(4'b0100,  2, 2'd0, 3'd0, 1'b0, 2'd0, 2'd0);
    tbl[13] = mk(4'b1100,  2, 2'd0, 3'd0, 1'b0, 2'd0, 2'd0);
    tbl[14] = mk(4'b0000, 13, 2'd0, 3'd0, 1'b0, 2'd0, 2'd0);
    tbl[15] = mk(4'b0000,  1, 2'd0, 3'd1, 1'b1, 2'd0, 2'd0);
    tbl[16] = mk(4'b0001,  1, 2'd0, 3'd1, 1'b0, 2'd0, 2'd1);
    tbl[17] = mk(4'b0001,  1, 2'd0, 3'd1, 1'b0, 2'd0, 2'd2);
    tbl[18] = mk(4'b0000, 61, 2'd0, 3'd1, 1'b0, 2'd0, 2'd2);
    tbl[19] = mk(4'b0000,  1, 2'd0, 3'd2, 1'b1, 2'd0, 2'd2);
    tbl[20] = mk(4'b0000, 63, 2'd0, 3'd2, 1'b0, 2'd0, 2'd2);
    tbl[21] = mk(4'b0000,  1, 2'd0, 3'd3, 1'b1, 2'd0, 2'd2);
    tbl[22] = mk(4'b0001,  1, 2'd0, 3'd3, 1'b0, 2'd0, 2'd3);
    tbl[23] = mk(4'b0001,  1, 2'd0, 3'd3, 1'b0, 2'd0, 2'd0);
    tbl[24] = mk(4'b0000, 14, 2'd0, 3'd4, 1'b1, 2'd0, 2'd0);

    RST = 1'b0;
    {UP_P, DOWN_P, MODE_P, SPEED_P} = 4'b0000;
    repeat (3) @(negedge CLK);
    check("reset", 2'd0, 3'd0, 1'b0, 2'd0, 2'd0);
    RST = 1'b1;

    for (int i = 0; i < 25; i++) begin
      pulse(tbl[i].p, tbl[i].w);
      check($sformatf("tbl%0d", i), tbl[i].pat, tbl[i].step, tbl[i].en, tbl[i].mode, tbl[i].speed);
    end

    // AUTO: 16 steps on the left pattern, then an UP press landing on an auto-advance
    pulse(4'b1010, 2);
    check("auto_enter", 2'd1, 3'd0, 1'b0, 2'd1, 2'd0);
    pulse(4'b0000, 255);
    check("auto_pre", 2'd1, 3'd3, 1'b0, 2'd1, 2'd0);
    pulse(4'b0000, 1);
    check("auto_adv", 2'd2, 3'd0, 1'b1, 2'd1, 2'd0);
    pulse(4'b0000, 254);
    check("auto_pre2", 2'd2, 3'd3, 1'b0, 2'd1, 2'd0);
    pulse(4'b1000, 2);
    check("auto_up_once", 2'd0, 3'd0, 1'b0, 2'd1, 2'd0);

    // PAUSE at STEP=3, hold for 100 clocks, DOWN while paused, then resume
    pulse(4'b0000, 48);
    check("pause_pre", 2'd0, 3'd3, 1'b1, 2'd1, 2'd0);
    pulse(4'b0010, 1);
    check("pause_enter", 2'd0, 3'd3, 1'b0, 2'd2, 2'd0);
    for (int i = 0; i < 100; i++) begin
      pulse(4'b0000, 1);
      check("pause_hold", 2'd0, 3'd3, 1'b0, 2'd2, 2'd0);
    end
    pulse(4'b0100, 2);
    check("pause_down", 2'd2, 3'd0, 1'b0, 2'd2, 2'd0);
    pulse(4'b0010, 1);
    check("pause_exit", 2'd2, 3'd0, 1'b0, 2'd0, 2'd0);
    pulse(4'b0000, 15);
    check("resume_wait", 2'd2, 3'd0, 1'b0, 2'd0, 2'd0);
    pulse(4'b0000, 1);
    check("resume_step", 2'd2, 3'd1, 1'b1, 2'd0, 2'd0);

    // Asynchronous reset mid-sweep in AUTO at SPEED=3
    pulse(4'b0010, 1);
    pulse(4'b0001, 1);
    pulse(4'b0001, 1);
    pulse(4'b0001, 200);
    check("async_pre", 2'd2, 3'd2, 1'b0, 2'd1, 2'd3);
    @(posedge CLK);
    #2 RST = 1'b0;
    #1 check("async_reset", 2'd0, 3'd0, 1'b0, 2'd0, 2'd0);
    @(negedge CLK);
    RST = 1'b1;

    for (int i = 0; i < 6000; i++) begin
      check_model("rand");
      if (i == 3000) begin
        @(posedge CLK);
        #3 RST = 1'b0;
        #1 check_model("rand_async");
        @(negedge CLK);
        RST = 1'b1;
      end
      UP_P    = ($urandom_range(199) == 0);
      DOWN_P  = ($urandom_range(199) == 0);
      if ($urandom_range(599) == 0) begin
        UP_P   = 1'b1;
        DOWN_P = 1'b1;
      end
      MODE_P  = ($urandom_range(349) == 0);
      SPEED_P = ($urandom_range(699) == 0);
      @(negedge CLK);
    end
    {UP_P, DOWN_P, MODE_P, SPEED_P} = 4'b0000;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
